// File: rtl/membus_fabric.sv
// membus_fabric: single-master memory-bus interconnect with base/mask decode, registered
// request/ready handshake, per-slave wait states and sticky error capture (timeout: MEMBUS_TIMEOUT_EN).
module membus_fabric #(
    parameter int unsigned NUM_SLAVES = 3,
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE = {32'h4000_0020, 32'h4000_0010, 32'h0000_0000},
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK = {32'hFFFF_FFE0, 32'hFFFF_FFFF, 32'hFFFF_F800},
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     m_read,
    input  logic                     m_write,
    input  logic [31:0]              m_address,
    input  logic [31:0]              m_write_data,
    output logic [31:0]              m_read_data,
    output logic                     m_ready,
    output logic                     m_error,
    output logic [NUM_SLAVES-1:0]    s_read,
    output logic [NUM_SLAVES-1:0]    s_write,
    output logic [31:0]              s_address,
    output logic [31:0]              s_write_data,
    input  logic [NUM_SLAVES*32-1:0] s_read_data,
    input  logic [NUM_SLAVES-1:0]    s_ready,
    input  logic                     err_clear,
    output logic [1:0]               err_code,
    output logic [31:0]              err_addr
);

    localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    if (NUM_SLAVES < 1 || NUM_SLAVES > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("membus_fabric: NUM_SLAVES must be 1..8 and TIMEOUT_CYCLES 1..65535");
    end

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      hit_idx;
    logic                  hit;
    logic                  op_write;
    logic [NUM_SLAVES-1:0] hit_onehot;
    logic                  sel_ready;
    logic [31:0]           sel_data;

    // Scan from the top so the lowest matching index is the last one written.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned i = NUM_SLAVES; i > 0; i--) begin
            if ((m_address & SLAVE_MASK[32*(i-1) +: 32]) == SLAVE_BASE[32*(i-1) +: 32]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i - 1);
            end
        end
    end

    assign hit_onehot = NUM_SLAVES'(1) << hit_idx;
    assign sel_ready  = s_ready[idx];
    assign sel_data   = s_read_data[32*idx +: 32];

`ifdef MEMBUS_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic        tmo_hit;
    assign tmo_hit = (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            idx          <= '0;
            op_write     <= 1'b0;
            m_read_data  <= '0;
            m_ready      <= 1'b0;
            m_error      <= 1'b0;
            s_read       <= '0;
            s_write      <= '0;
            s_address    <= '0;
            s_write_data <= '0;
            err_code     <= '0;
            err_addr     <= '0;
`ifdef MEMBUS_TIMEOUT_EN
            tmo_cnt      <= '0;
`endif
        end else begin
            // A capture later in this block overrides the clear, so a same-cycle error is kept.
            if (err_clear) begin
                err_code <= '0;
                err_addr <= '0;
            end
            case (state)
                IDLE: begin
                    m_ready     <= 1'b0;
                    m_error     <= 1'b0;
                    m_read_data <= '0;
                    if (m_read || m_write) begin
                        s_address    <= m_address;
                        s_write_data <= m_write_data;
                        op_write     <= m_write;
                        idx          <= hit_idx;
                        if (hit) begin
                            state <= ACCESS;
                            if (m_write) s_write <= hit_onehot;
                            else         s_read  <= hit_onehot;
`ifdef MEMBUS_TIMEOUT_EN
                            tmo_cnt <= '0;
`endif
                        end else begin
                            state   <= RESP;
                            m_ready <= 1'b1;
                            m_error <= 1'b1;
                            if (err_code == 2'b00 || err_clear) begin
                                err_code <= 2'b01;
                                err_addr <= m_address;
                            end
                        end
                    end
                end
                ACCESS: begin
                    if (sel_ready) begin
                        s_read      <= '0;
                        s_write     <= '0;
                        state       <= RESP;
                        m_ready     <= 1'b1;
                        m_read_data <= op_write ? '0 : sel_data;
                    end
`ifdef MEMBUS_TIMEOUT_EN
                    else if (tmo_hit) begin
                        s_read  <= '0;
                        s_write <= '0;
                        state   <= RESP;
                        m_ready <= 1'b1;
                        m_error <= 1'b1;
                        if (err_code == 2'b00 || err_clear) begin
                            err_code <= 2'b10;
                            err_addr <= s_address;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
`endif
                end
                RESP: begin
                    m_ready     <= 1'b0;
                    m_error     <= 1'b0;
                    m_read_data <= '0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_membus_fabric.sv
// tb_membus_fabric: directed scoreboard bench for membus_fabric; responses and strobes are
// queued at issue time and checked by independent monitors. Honours MEMBUS_TIMEOUT_EN.
module tb_membus_fabric;

    localparam int unsigned NS = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          m_read = 1'b0;
    logic          m_write = 1'b0;
    logic [31:0]   m_address = '0;
    logic [31:0]   m_write_data = '0;
    logic [31:0]   m_read_data;
    logic          m_ready;
    logic          m_error;
    logic [NS-1:0] s_read;
    logic [NS-1:0] s_write;
    logic [31:0]   s_address;
    logic [31:0]   s_write_data;
    logic [NS*32-1:0] s_read_data;
    logic [NS-1:0] s_ready;
    logic          err_clear = 1'b0;
    logic [1:0]    err_code;
    logic [31:0]   err_addr;

    membus_fabric #(
        .NUM_SLAVES(NS),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .reset(reset),
        .m_read(m_read), .m_write(m_write), .m_address(m_address), .m_write_data(m_write_data),
        .m_read_data(m_read_data), .m_ready(m_ready), .m_error(m_error),
        .s_read(s_read), .s_write(s_write), .s_address(s_address), .s_write_data(s_write_data),
        .s_read_data(s_read_data), .s_ready(s_ready),
        .err_clear(err_clear), .err_code(err_code), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] data; logic err; } resp_t;
    typedef struct { logic [NS-1:0] rd; logic [NS-1:0] wr; logic [31:0] addr; logic [31:0] wdata; } strb_t;

    resp_t resp_q[$];
    strb_t strb_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Slave model: each slave raises s_ready after wait_cfg[i] strobe cycles.
    assign s_read_data = {32'hBBBB_0002, 32'hAAAA_0001, 32'h1234_5678};
    int unsigned wait_cfg [NS];
    int unsigned busy [NS];

    always @(posedge clk)
        for (int i = 0; i < NS; i++)
            busy[i] <= (s_read[i] || s_write[i]) ? busy[i] + 1 : 0;

    always_comb begin
        s_ready = '0;
        for (int i = 0; i < NS; i++)
            s_ready[i] = (s_read[i] || s_write[i]) && (busy[i] >= wait_cfg[i]);
    end

    logic [NS-1:0] prev_strb = '0;

    always @(negedge clk) begin : resp_monitor
        resp_t r;
        if (m_ready === 1'b1) begin
            if (resp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_m_ready: got m_ready=1 expected no response (t=%0t)", $time);
            end else begin
                r = resp_q.pop_front();
                check("resp_data", m_read_data, r.data);
                check("resp_error", 32'(m_error), 32'(r.err));
            end
        end
    end

    always @(negedge clk) begin : strobe_monitor
        strb_t s;
        if ((s_read | s_write) != '0 && prev_strb == '0) begin
            if (strb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_strobe: got rd=%b wr=%b expected none (t=%0t)", s_read, s_write, $time);
            end else begin
                s = strb_q.pop_front();
                check("strobe_read", 32'(s_read), 32'(s.rd));
                check("strobe_write", 32'(s_write), 32'(s.wr));
                check("strobe_addr", s_address, s.addr);
                check("strobe_wdata", s_write_data, s.wdata);
            end
        end
        prev_strb = s_read | s_write;
    end

    // Drives one request until m_ready; lat counts cycles after the sampling cycle.
    task automatic do_xfer(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           output int lat, output int strb_first, output int strb_len);
        int n = 0;
        strb_first = -1;
        strb_len = 0;
        m_read = rd;
        m_write = wr;
        m_address = addr;
        m_write_data = wdata;
        while (n < 2000) begin
            @(negedge clk);
            n++;
            if ((s_read | s_write) != '0) begin
                strb_len++;
                if (strb_first < 0) strb_first = n;
            end
            if (m_ready === 1'b1) break;
        end
        m_read = 1'b0;
        m_write = 1'b0;
        if (m_ready !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL xfer_bound: got no m_ready expected m_ready within 2000 cycles (addr %h)", addr);
        end
        lat = n - 1;
    endtask

    initial begin : watchdog
        #1_000_000;
        n_bad++;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int lat, sf, sl;
        wait_cfg[0] = 0;
        wait_cfg[1] = 4;
        wait_cfg[2] = 0;

        #12;
        check("rst_m_ready", 32'(m_ready), 32'h0);
        check("rst_m_error", 32'(m_error), 32'h0);
        check("rst_m_read_data", m_read_data, 32'h0);
        check("rst_s_read", 32'(s_read), 32'h0);
        check("rst_s_write", 32'(s_write), 32'h0);
        check("rst_s_address", s_address, 32'h0);
        check("rst_err_code", 32'(err_code), 32'h0);
        check("rst_err_addr", err_addr, 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        // Zero-wait read from slave 0.
        strb_q.push_back('{rd: 3'b001, wr: 3'b000, addr: 32'h0000_0124, wdata: 32'h0});
        resp_q.push_back('{data: 32'h1234_5678, err: 1'b0});
        do_xfer(1'b1, 1'b0, 32'h0000_0124, 32'h0, lat, sf, sl);
        check("rd0_latency", 32'(lat), 32'd2);
        check("rd0_strobe_len", 32'(sl), 32'd1);

        // Write to slave 1 with four wait states.
        strb_q.push_back('{rd: 3'b000, wr: 3'b010, addr: 32'h4000_0010, wdata: 32'h0000_00FF});
        resp_q.push_back('{data: 32'h0, err: 1'b0});
        do_xfer(1'b0, 1'b1, 32'h4000_0010, 32'h0000_00FF, lat, sf, sl);
        check("wr1_latency", 32'(lat), 32'd6);
        check("wr1_strobe_len", 32'(sl), 32'd5);

        // Read+write together is a write; then a back-to-back read.
        wait_cfg[1] = 0;
        strb_q.push_back('{rd: 3'b000, wr: 3'b100, addr: 32'h4000_0024, wdata: 32'hDEAD_BEEF});
        resp_q.push_back('{data: 32'h0, err: 1'b0});
        do_xfer(1'b1, 1'b1, 32'h4000_0024, 32'hDEAD_BEEF, lat, sf, sl);
        check("rw2_latency", 32'(lat), 32'd2);
        strb_q.push_back('{rd: 3'b010, wr: 3'b000, addr: 32'h4000_0010, wdata: 32'h0});
        resp_q.push_back('{data: 32'hAAAA_0001, err: 1'b0});
        do_xfer(1'b1, 1'b0, 32'h4000_0010, 32'h0, lat, sf, sl);
        check("b2b_strobe_start", 32'(sf), 32'd2);
        check("b2b_latency", 32'(lat), 32'd2);

        // Decode misses and sticky capture.
        resp_q.push_back('{data: 32'h0, err: 1'b1});
        do_xfer(1'b1, 1'b0, 32'h8000_0000, 32'h0, lat, sf, sl);
        check("miss_latency", 32'(lat), 32'd1);
        check("miss_strobe_len", 32'(sl), 32'd0);
        check("miss_err_code", 32'(err_code), 32'h1);
        check("miss_err_addr", err_addr, 32'h8000_0000);
        resp_q.push_back('{data: 32'h0, err: 1'b1});
        do_xfer(1'b1, 1'b0, 32'h9000_0000, 32'h0, lat, sf, sl);
        check("miss2_err_addr", err_addr, 32'h8000_0000);
        check("miss2_err_code", 32'(err_code), 32'h1);

        @(posedge clk);
        #1 err_clear = 1'b1;
        fork
            begin
                @(posedge clk);
                #1 err_clear = 1'b0;
            end
        join_none
        resp_q.push_back('{data: 32'h0, err: 1'b1});
        do_xfer(1'b1, 1'b0, 32'hA000_0000, 32'h0, lat, sf, sl);
        check("clr_miss_err_code", 32'(err_code), 32'h1);
        check("clr_miss_err_addr", err_addr, 32'hA000_0000);
        @(posedge clk);
        #1 err_clear = 1'b1;
        @(posedge clk);
        #1 err_clear = 1'b0;
        check("clear_err_code", 32'(err_code), 32'h0);
        check("clear_err_addr", err_addr, 32'h0);

        wait_cfg[2] = 1_000_000;
`ifdef MEMBUS_TIMEOUT_EN
        strb_q.push_back('{rd: 3'b100, wr: 3'b000, addr: 32'h4000_0020, wdata: 32'h0});
        resp_q.push_back('{data: 32'h0, err: 1'b1});
        do_xfer(1'b1, 1'b0, 32'h4000_0020, 32'h0, lat, sf, sl);
        check("tmo_latency", 32'(lat), 32'd9);
        check("tmo_strobe_len", 32'(sl), 32'd8);
        check("tmo_err_code", 32'(err_code), 32'h2);
        check("tmo_err_addr", err_addr, 32'h4000_0020);
        strb_q.push_back('{rd: 3'b100, wr: 3'b000, addr: 32'h4000_0020, wdata: 32'h0});
        m_read = 1'b1;
        m_address = 32'h4000_0020;
        repeat (3) @(negedge clk);
        check("hang_strobe", 32'(s_read), 32'h4);
`else
        strb_q.push_back('{rd: 3'b100, wr: 3'b000, addr: 32'h4000_0020, wdata: 32'h0});
        m_read = 1'b1;
        m_address = 32'h4000_0020;
        repeat (1000) @(negedge clk);
        check("pending_strobe", 32'(s_read), 32'h4);
        check("pending_no_ready", 32'(m_ready), 32'h0);
`endif

        // Asynchronous reset in the middle of ACCESS.
        #2 reset = 1'b0;
        #1;
        check("arst_s_read", 32'(s_read), 32'h0);
        check("arst_s_write", 32'(s_write), 32'h0);
        check("arst_m_ready", 32'(m_ready), 32'h0);
        check("arst_err_code", 32'(err_code), 32'h0);
        m_read = 1'b0;
        wait_cfg[2] = 0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        strb_q.push_back('{rd: 3'b001, wr: 3'b000, addr: 32'h0000_0124, wdata: 32'h0});
        resp_q.push_back('{data: 32'h1234_5678, err: 1'b0});
        do_xfer(1'b1, 1'b0, 32'h0000_0124, 32'h0, lat, sf, sl);
        check("post_rst_latency", 32'(lat), 32'd2);

        repeat (3) @(negedge clk);
        check("resp_q_drained", 32'(resp_q.size()), 32'd0);
        check("strb_q_drained", 32'(strb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
